// File: rtl/dma_burst_engine.sv
// DMA engine moving word blocks between the system bus and an internal dual-port buffer
// in bursts, configured and observed by the CPU through the custom-instruction port.
module dma_burst_engine #(
    parameter logic [7:0] CUSTOM_ID      = 8'h00,
    parameter int         ADDR_WIDTH     = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         BUF_ADDR_WIDTH = 9,
    parameter int         BLOCK_WIDTH    = 10,
    parameter int         BURST_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ci_start,
    input  logic [7:0]             ci_n,
    input  logic [31:0]            value_a,
    input  logic [DATA_WIDTH-1:0]  value_b,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   done,
    output logic                   bus_request,
    input  logic                   bus_grant,
    output logic                   begin_transaction_out,
    output logic [ADDR_WIDTH-1:0]  address_out,
    output logic [BURST_WIDTH-1:0] burst_size_out,
    output logic                   read_n_write_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid_out,
    input  logic                   bus_busy,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid_in,
    input  logic                   end_transaction_in,
    output logic                   end_transaction_out,
    input  logic                   bus_error
);

    localparam int DEPTH = 2 ** BUF_ADDR_WIDTH;
    localparam int LW    = ((BLOCK_WIDTH > BURST_WIDTH) ? BLOCK_WIDTH : BURST_WIDTH) + 1;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_REQUEST, S_BEGIN, S_READ, S_WRITE, S_ENDW, S_NEXT
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     busAddr_q, busAddr_d, curBus_q, curBus_d;
    logic [BUF_ADDR_WIDTH-1:0] bufAddr_q, bufAddr_d, curBuf_q, curBuf_d;
    logic [BLOCK_WIDTH-1:0]    blockSize_q, blockSize_d, remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0]    burstSize_q, burstSize_d;
    logic [LW-1:0]             beat_q, beat_d;
    logic                      dirRead_q, dirRead_d;
    logic                      error_q, error_d;
    logic                      done_q, bufRd_q;
    logic [DATA_WIDTH-1:0]     regRd_q, regRd_d, memRd_q;

    logic                      ciAccept, ciWrite, cfgWrite, busy;
    logic                      ctrlWrite, startRead, startWrite, clearErr;
    logic [2:0]                ciSel;
    logic [BUF_ADDR_WIDTH-1:0] ciBufAddr, dmaAddr;
    logic [LW-1:0]             burstLen, remainLen, curLen;
    logic                      ciMemWe, dmaMemWe;
    logic                      unusedBits;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign ciAccept   = ci_start && (ci_n == CUSTOM_ID);
    assign ciSel      = value_a[12:10];
    assign ciWrite    = value_a[9];
    assign ciBufAddr  = value_a[BUF_ADDR_WIDTH-1:0];
    assign unusedBits = ^value_a[31:13];
    assign busy       = (state_q != S_IDLE);
    assign cfgWrite   = ciAccept && ciWrite && !busy;
    assign ctrlWrite  = cfgWrite && (ciSel == 3'd5);
    assign startRead  = ctrlWrite && (value_b[1:0] == 2'd1);
    assign startWrite = ctrlWrite && (value_b[1:0] == 2'd2);
    assign clearErr   = ctrlWrite && (value_b[1:0] == 2'd0);

    // Beats in the current burst: the configured length, cut short by what is left of the block.
    assign burstLen  = LW'(burstSize_q) + LW'(1);
    assign remainLen = LW'(remaining_q);
    assign curLen    = (burstLen < remainLen) ? burstLen : remainLen;
    assign dmaAddr   = curBuf_q + BUF_ADDR_WIDTH'(beat_q);

    assign ciMemWe  = ciAccept && ciWrite && (ciSel == 3'd0);
    assign dmaMemWe = (state_q == S_READ) && data_valid_in && (beat_q < curLen);

    // Buffer: the DMA write is issued last so it wins a same-address collision with the CPU.
    always_ff @(posedge clock) begin
        if (ciMemWe) mem[ciBufAddr] <= value_b;
        if (dmaMemWe) mem[dmaAddr] <= data_in;
        memRd_q <= mem[ciBufAddr];
    end

    assign bus_request           = (state_q == S_REQUEST) || (state_q == S_BEGIN) ||
                                   (state_q == S_READ) || (state_q == S_WRITE) ||
                                   (state_q == S_ENDW);
    assign begin_transaction_out = (state_q == S_BEGIN);
    assign address_out           = begin_transaction_out ? curBus_q : '0;
    assign burst_size_out        = begin_transaction_out ? BURST_WIDTH'(curLen - LW'(1)) : '0;
    assign read_n_write_out      = begin_transaction_out && dirRead_q;
    assign data_valid_out        = (state_q == S_WRITE);
    assign data_out              = data_valid_out ? mem[dmaAddr] : '0;
    assign end_transaction_out   = (state_q == S_ENDW);
    assign done                  = done_q;
    assign result                = bufRd_q ? memRd_q : regRd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busAddr_q   <= '0;
            bufAddr_q   <= '0;
            blockSize_q <= '0;
            burstSize_q <= '0;
            curBus_q    <= '0;
            curBuf_q    <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            dirRead_q   <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            bufRd_q     <= 1'b0;
            regRd_q     <= '0;
        end else begin
            state_q     <= state_d;
            busAddr_q   <= busAddr_d;
            bufAddr_q   <= bufAddr_d;
            blockSize_q <= blockSize_d;
            burstSize_q <= burstSize_d;
            curBus_q    <= curBus_d;
            curBuf_q    <= curBuf_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            dirRead_q   <= dirRead_d;
            error_q     <= error_d;
            done_q      <= ciAccept;
            bufRd_q     <= ciAccept && !ciWrite && (ciSel == 3'd0);
            regRd_q     <= regRd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busAddr_d   = busAddr_q;
        bufAddr_d   = bufAddr_q;
        blockSize_d = blockSize_q;
        burstSize_d = burstSize_q;
        curBus_d    = curBus_q;
        curBuf_d    = curBuf_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        dirRead_d   = dirRead_q;
        error_d     = error_q;
        regRd_d     = '0;

        if (ciAccept && !ciWrite) begin
            case (ciSel)
                3'd1:    regRd_d = DATA_WIDTH'(busAddr_q);
                3'd2:    regRd_d = DATA_WIDTH'(bufAddr_q);
                3'd3:    regRd_d = DATA_WIDTH'(blockSize_q);
                3'd4:    regRd_d = DATA_WIDTH'(burstSize_q);
                3'd5:    regRd_d = DATA_WIDTH'({error_q, busy});
                default: regRd_d = '0;
            endcase
        end

        if (cfgWrite) begin
            case (ciSel)
                3'd1:    busAddr_d   = ADDR_WIDTH'(value_b);
                3'd2:    bufAddr_d   = BUF_ADDR_WIDTH'(value_b);
                3'd3:    blockSize_d = BLOCK_WIDTH'(value_b);
                3'd4:    burstSize_d = BURST_WIDTH'(value_b);
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (clearErr) error_d = 1'b0;
                if ((startRead || startWrite) && (blockSize_q != '0)) begin
                    remaining_d = blockSize_q;
                    curBus_d    = busAddr_q;
                    curBuf_d    = bufAddr_q;
                    dirRead_d   = startRead;
                    beat_d      = '0;
                    state_d     = S_REQUEST;
                end
            end
            S_REQUEST: if (bus_grant) state_d = S_BEGIN;
            S_BEGIN: begin
                beat_d  = '0;
                state_d = dirRead_q ? S_READ : S_WRITE;
            end
            S_READ: begin
                if (dmaMemWe) beat_d = beat_q + LW'(1);
                if (end_transaction_in) state_d = S_NEXT;
            end
            S_WRITE: begin
                if (!bus_busy) begin
                    beat_d = beat_q + LW'(1);
                    if (beat_q == curLen - LW'(1)) state_d = S_ENDW;
                end
            end
            S_ENDW: state_d = S_NEXT;
            S_NEXT: begin
                remaining_d = remaining_q - BLOCK_WIDTH'(beat_q);
                curBus_d    = curBus_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES);
                curBuf_d    = curBuf_q + BUF_ADDR_WIDTH'(beat_q);
                beat_d      = '0;
                state_d     = (remaining_q == BLOCK_WIDTH'(beat_q)) ? S_IDLE : S_REQUEST;
            end
            default: state_d = S_IDLE;
        endcase

        // A bus error abandons whatever is left of the block.
        if (busy && bus_error) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            beat_d  = '0;
        end
    end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Randomised bench for dma_burst_engine: a bus slave model and a buffer model
// predict every burst header, write beat and buffer word.
module tb_dma_burst_engine;

    localparam logic [7:0] CID = 8'h00;

    logic        clock = 1'b0;
    logic        reset;
    logic        ci_start;
    logic [7:0]  ci_n;
    logic [31:0] value_a, value_b, result;
    logic        done;
    logic        bus_request, bus_grant, begin_transaction_out;
    logic [31:0] address_out;
    logic [7:0]  burst_size_out;
    logic        read_n_write_out;
    logic [31:0] data_out, data_in;
    logic        data_valid_out, bus_busy, data_valid_in;
    logic        end_transaction_in, end_transaction_out, bus_error;

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] bufModel [512];
    logic [31:0] rd;

    dma_burst_engine #(.CUSTOM_ID(CID)) dut (
        .clock(clock), .reset(reset), .ci_start(ci_start), .ci_n(ci_n),
        .value_a(value_a), .value_b(value_b), .result(result), .done(done),
        .bus_request(bus_request), .bus_grant(bus_grant),
        .begin_transaction_out(begin_transaction_out), .address_out(address_out),
        .burst_size_out(burst_size_out), .read_n_write_out(read_n_write_out),
        .data_out(data_out), .data_valid_out(data_valid_out), .bus_busy(bus_busy),
        .data_in(data_in), .data_valid_in(data_valid_in),
        .end_transaction_in(end_transaction_in), .end_transaction_out(end_transaction_out),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One CI operation: issued after a falling edge, done/result sampled one cycle later.
    task automatic applyStimulus(input logic [2:0] sel, input bit we, input int addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        ci_n     = CID;
        value_a  = {19'd0, sel, we, 9'(addr)};
        value_b  = wdata;
        ci_start = 1'b1;
        @(negedge clock);
        ci_start = 1'b0;
        value_a  = '0;
        checkOutput($sformatf("done sel%0d", sel), {63'd0, done}, 64'd1);
        rdata = result;
    endtask

    task automatic ciWrite(input logic [2:0] sel, input int addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        applyStimulus(sel, 1'b1, addr, wdata, dummy);
    endtask

    task automatic ciCheck(input string tag, input logic [2:0] sel, input int addr, input logic [31:0] expected);
        logic [31:0] r;
        applyStimulus(sel, 1'b0, addr, '0, r);
        checkOutput(tag, {32'd0, r}, {32'd0, expected});
    endtask

    task automatic programRegs(input logic [31:0] busA, input int bufA, input int blk, input int bst);
        ciWrite(3'd1, 0, busA);
        ciWrite(3'd2, 0, 32'(bufA));
        ciWrite(3'd3, 0, 32'(blk));
        ciWrite(3'd4, 0, 32'(bst));
    endtask

    task automatic fillBuffer(input int start, input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            ciWrite(3'd0, (start + i) % 512, d);
            bufModel[(start + i) % 512] = d;
        end
    endtask

    task automatic checkBuffer(input int start, input int n);
        for (int i = 0; i < n; i++)
            ciCheck($sformatf("buffer[%0d]", (start + i) % 512), 3'd0, (start + i) % 512,
                    bufModel[(start + i) % 512]);
    endtask

    task automatic abortBus(input int kind);
        if (kind == 1) bus_error = 1'b1;
        else reset = 1'b1;
        @(negedge clock);
        bus_error = 1'b0;
        reset     = 1'b0;
        checkOutput("busCtrlIdle", {27'd0, bus_request, begin_transaction_out, read_n_write_out,
                    data_valid_out, end_transaction_out, address_out}, 64'd0);
        checkOutput("busDataIdle", {24'd0, burst_size_out, data_out}, 64'd0);
    endtask

    // Bus slave plus reference: expected bursts follow from block/burst arithmetic alone.
    task automatic serveBus(input bit isRead, input int block, input int burst,
                            input logic [31:0] busStart, input int bufStart, input logic [31:0] dataBase,
                            input int stallBeat, input bit randStall, input int abortBeat, input int abortKind);
        int rem, len, idx, burstNo, b, waitCnt, stallsDone;
        bit stall, aborted;
        logic [31:0] busAddr;
        rem = block; busAddr = busStart; idx = 0; burstNo = 0; aborted = 0; stallsDone = 0;
        while (rem > 0 && !aborted) begin
            len = (burst + 1 < rem) ? burst + 1 : rem;
            waitCnt = 0;
            while (bus_request !== 1'b1 && waitCnt < 50) begin
                @(negedge clock);
                waitCnt++;
            end
            if (bus_request !== 1'b1) begin
                checkOutput("requestTimeout", {63'd0, bus_request}, 64'd1);
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                checkOutput("requestHold", {63'd0, bus_request}, 64'd1);
            end
            bus_grant = 1'b1;
            @(negedge clock);
            bus_grant = 1'b0;
            checkOutput("beginStrobe", {63'd0, begin_transaction_out}, 64'd1);
            checkOutput("address", {32'd0, address_out}, {32'd0, busAddr});
            checkOutput("burstSize", {56'd0, burst_size_out}, 64'(len - 1));
            checkOutput("readNWrite", {63'd0, read_n_write_out}, {63'd0, isRead});
            @(negedge clock);
            b = 0;
            while (b < len) begin
                if (burstNo == 0 && b == abortBeat) begin
                    abortBus(abortKind);
                    aborted = 1;
                    break;
                end
                if (isRead) begin
                    if ($urandom_range(0, 3) == 0) data_valid_in = 1'b0;
                    else begin
                        data_valid_in = 1'b1;
                        data_in = dataBase + 32'(idx);
                        bufModel[(bufStart + idx) % 512] = dataBase + 32'(idx);
                        idx++;
                        b++;
                    end
                    @(negedge clock);
                    data_valid_in = 1'b0;
                end else begin
                    checkOutput("dataValid", {63'd0, data_valid_out}, 64'd1);
                    checkOutput("writeData", {32'd0, data_out}, {32'd0, bufModel[(bufStart + idx) % 512]});
                    stall = 0;
                    if (burstNo == 0 && b == stallBeat && stallsDone < 2) begin
                        stall = 1;
                        stallsDone++;
                    end else if (randStall) stall = ($urandom_range(0, 3) == 0);
                    bus_busy = stall;
                    @(negedge clock);
                    bus_busy = 1'b0;
                    if (!stall) begin
                        idx++;
                        b++;
                    end
                end
            end
            if (aborted) break;
            if (isRead) begin
                if ($urandom_range(0, 1) == 1) begin
                    data_valid_in = 1'b1;
                    data_in = 32'hDEAD_BEEF;
                end
                end_transaction_in = 1'b1;
                @(negedge clock);
                end_transaction_in = 1'b0;
                data_valid_in = 1'b0;
            end else begin
                checkOutput("endTransaction", {63'd0, end_transaction_out}, 64'd1);
                @(negedge clock);
            end
            checkOutput("requestDrop", {63'd0, bus_request}, 64'd0);
            rem -= len;
            busAddr += 32'(4 * len);
            burstNo++;
        end
        if (!aborted) begin
            @(negedge clock);
            checkOutput("idleAfter", {63'd0, bus_request}, 64'd0);
        end
    endtask

    initial begin
        int isRead, blk, bst, bufS;
        logic [31:0] busS, base;
        reset = 1'b1; ci_start = 0; ci_n = CID; value_a = 0; value_b = 0;
        bus_grant = 0; bus_busy = 0; data_in = 0; data_valid_in = 0;
        end_transaction_in = 0; bus_error = 0;
        repeat (3) @(negedge clock);
        checkOutput("resetBus", {27'd0, bus_request, begin_transaction_out, read_n_write_out,
                    data_valid_out, end_transaction_out, address_out}, 64'd0);
        checkOutput("resetCi", {31'd0, done, result}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        ciCheck("resetStatus", 3'd5, 0, 32'd0);

        programRegs(32'h1000_0040, 5, 8, 3);
        ciCheck("rtBusAddr", 3'd1, 0, 32'h1000_0040);
        ciCheck("rtBufAddr", 3'd2, 0, 32'd5);
        ciCheck("rtBlock", 3'd3, 0, 32'd8);
        ciCheck("rtBurst", 3'd4, 0, 32'd3);
        @(negedge clock);
        checkOutput("doneOneCycle", {31'd0, done, result}, 64'd0);
        ci_n = 8'h01; value_a = {19'd0, 3'd3, 1'b1, 9'd0}; value_b = 32'd3; ci_start = 1'b1;
        @(negedge clock);
        ci_start = 1'b0; ci_n = CID;
        checkOutput("wrongIdNoDone", {63'd0, done}, 64'd0);
        ciCheck("wrongIdNoWrite", 3'd3, 0, 32'd8);
        ciCheck("unusedSel6", 3'd6, 0, 32'd0);

        ciWrite(3'd5, 0, 32'd1);
        serveBus(1, 8, 3, 32'h1000_0040, 5, 32'hA0, -1, 0, -1, 0);
        ciCheck("readFirstWord", 3'd0, 5, 32'hA0);
        ciCheck("readLastWord", 3'd0, 12, 32'hA7);
        checkBuffer(5, 8);
        ciCheck("readDoneStatus", 3'd5, 0, 32'd0);

        fillBuffer(100, 5);
        programRegs(32'h2000_0000, 100, 5, 3);
        ciWrite(3'd5, 0, 32'd2);
        serveBus(0, 5, 3, 32'h2000_0000, 100, 32'd0, 2, 0, -1, 0);
        ciCheck("writeDoneStatus", 3'd5, 0, 32'd0);

        programRegs(32'h3000_0000, 510, 4, 3);
        ciWrite(3'd5, 0, 32'd1);
        serveBus(1, 4, 3, 32'h3000_0000, 510, 32'h5A00, -1, 0, -1, 0);
        ciCheck("wrap510", 3'd0, 510, 32'h5A00);
        ciCheck("wrap511", 3'd0, 511, 32'h5A01);
        ciCheck("wrap0", 3'd0, 0, 32'h5A02);
        ciCheck("wrap1", 3'd0, 1, 32'h5A03);

        programRegs(32'h4000_0000, 20, 8, 3);
        ciWrite(3'd5, 0, 32'd1);
        ciWrite(3'd3, 0, 32'd99);
        ciWrite(3'd1, 0, 32'h0000_FFFF);
        ciCheck("busyBlockKept", 3'd3, 0, 32'd8);
        ciCheck("busyAddrKept", 3'd1, 0, 32'h4000_0000);
        ciCheck("statusBusy", 3'd5, 0, 32'd1);
        serveBus(1, 8, 3, 32'h4000_0000, 20, 32'h7700, -1, 0, 2, 1);
        ciCheck("statusError", 3'd5, 0, 32'd2);
        ciWrite(3'd5, 0, 32'd0);
        ciCheck("statusCleared", 3'd5, 0, 32'd0);

        programRegs(32'h5000_0000, 0, 0, 3);
        ciWrite(3'd5, 0, 32'd1);
        checkOutput("zeroBlockNoRequest", {63'd0, bus_request}, 64'd0);
        ciCheck("zeroBlockStatus", 3'd5, 0, 32'd0);
        ciWrite(3'd3, 0, 32'd4);
        ciWrite(3'd5, 0, 32'd3);
        checkOutput("ctrl3NoRequest", {63'd0, bus_request}, 64'd0);
        ciCheck("ctrl3Status", 3'd5, 0, 32'd0);

        fillBuffer(200, 6);
        programRegs(32'h6000_0000, 200, 6, 3);
        ciWrite(3'd5, 0, 32'd2);
        serveBus(0, 6, 3, 32'h6000_0000, 200, 32'd0, -1, 1, 1, 2);
        ciCheck("resetStatusMid", 3'd5, 0, 32'd0);
        ciCheck("resetClearsBlock", 3'd3, 0, 32'd0);
        programRegs(32'h6000_0100, 200, 6, 2);
        ciWrite(3'd5, 0, 32'd2);
        serveBus(0, 6, 2, 32'h6000_0100, 200, 32'd0, -1, 1, -1, 0);
        ciCheck("afterResetStatus", 3'd5, 0, 32'd0);

        for (int it = 0; it < 8; it++) begin
            isRead = int'($urandom_range(0, 1));
            blk    = int'($urandom_range(1, 20));
            bst    = int'($urandom_range(0, 7));
            bufS   = int'($urandom_range(0, 511));
            busS   = $urandom & 32'hFFFF_FFFC;
            base   = $urandom;
            if (isRead == 0) fillBuffer(bufS, blk);
            programRegs(busS, bufS, blk, bst);
            ciWrite(3'd5, 0, (isRead == 1) ? 32'd1 : 32'd2);
            serveBus(isRead == 1, blk, bst, busS, bufS, base, -1, 1, -1, 0);
            if (isRead == 1) checkBuffer(bufS, blk);
            ciCheck($sformatf("randStatus%0d", it), 3'd5, 0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dma_burst_engine.md
Name: dma_burst_engine

Overview:
Parametrised custom-instruction DMA engine. Moves blocks of words between a system bus (bus master port) and an internal dual-port buffer, in bursts of configurable length. The CPU accesses the buffer and configuration/status registers through the custom-instruction (CI) interface. This is the successor to the single-width DMA controller: generic widths and depth, block split into multiple bursts with a short final burst, both directions, sticky error status and busy protection.

Parameters:
CUSTOM_ID, 8'h00, CI opcode this block responds to
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus/buffer word width (multiple of 8)
BUF_ADDR_WIDTH, 9, buffer depth = 2**BUF_ADDR_WIDTH words
BLOCK_WIDTH, 10, block-size register width (words)
BURST_WIDTH, 8, burst-size register width (beats-1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
ci_start  in  1  CI strobe, one cycle
ci_n  in  8  CI opcode; ignored unless == CUSTOM_ID
value_a  in  32  [12:10] register select, [9] write-enable, [BUF_ADDR_WIDTH-1:0] buffer address
value_b  in  DATA_WIDTH  CI write data
result  out  DATA_WIDTH  CI read data
done  out  1  CI completion
bus_request  out  1  bus request
bus_grant  in  1  arbiter grant
begin_transaction_out  out  1  transaction start strobe
address_out  out  ADDR_WIDTH  burst start address (valid with begin strobe)
burst_size_out  out  BURST_WIDTH  beats-1 of current burst
read_n_write_out  out  1  1 = bus read
data_out  out  DATA_WIDTH  write-beat data
data_valid_out  out  1  write beat valid
bus_busy  in  1  slave stall (write beats)
data_in  in  DATA_WIDTH  read-beat data
data_valid_in  in  1  read beat valid
end_transaction_in  in  1  slave ends read burst
end_transaction_out  out  1  master ends write burst
bus_error  in  1  bus error, abort

Behaviour:
- Reset: all outputs 0; registers 0; state IDLE; buffer contents not reset.
- CI op accepted when ci_start & ci_n==CUSTOM_ID. done = 1 exactly one cycle later, for one cycle; result is valid in the same cycle and 0 otherwise.
- value_a[12:10]: 0 buffer word (CI port), 1 bus start address, 2 buffer start address, 3 block size (words), 4 burst size (beats-1), 5 control (write) / status (read). Codes 6,7: done pulses, result 0, no effect.
- value_a[9]=1 writes value_b (truncated to register width); value_a[9]=0 reads (zero-extended).
- Writes to selects 1-5 while busy are ignored; done still pulses. Buffer access (select 0) is always allowed.
- Control write: value_b[1:0]=1 starts bus->buffer transfer; =2 starts buffer->bus transfer; =0 clears status error bit; =3 is ignored. Control is a strobe and is not stored.
- Status: bit0 busy, bit1 error (sticky).
- Start with block size 0: no transfer; busy stays 0.
- States:
  - IDLE: on valid start, set busy, load remaining=block size, cur_bus=bus start, cur_buf=buffer start -> REQUEST.
  - REQUEST: bus_request=1 until bus_grant is sampled 1 -> BEGIN.
  - BEGIN: one-cycle begin_transaction_out with address_out=cur_bus, burst_size_out=min(burst+1, remaining)-1 and read_n_write_out set -> READ or WRITE.
  - READ: each data_valid_in writes data_in into buffer[cur_buf+beat]. On end_transaction_in -> NEXT.
  - WRITE: data_out=buffer[cur_buf+beat], data_valid_out=1. A beat completes when data_valid_out & !bus_busy. After the last beat -> ENDW.
  - ENDW: end_transaction_out=1 for one cycle -> NEXT.
  - NEXT: remaining -= beats; cur_bus += beats*(DATA_WIDTH/8); cur_buf += beats (wraps mod depth). If remaining==0 -> IDLE with busy cleared; else -> REQUEST. bus_request is low for at least one cycle between bursts.
- bus_request stays high from REQUEST through the end of the burst; it drops on entering NEXT.
- Read beats arriving after the expected count are dropped. end_transaction_in before the expected count -> NEXT, counting only the received beats.
- bus_error in any non-IDLE state: next cycle all bus outputs 0, status error=1, busy=0, state IDLE. Remaining transfer is abandoned.
- Reset mid-transfer: all bus outputs 0 next cycle, state IDLE, status 0.
- Buffer conflict: a same-cycle CI write and DMA write to the same address lets the DMA win.
- The address adder wraps modulo 2**ADDR_WIDTH.

Test Plan:
- Register round-trip: write bus addr 0x1000_0040, buffer addr 5, block 8, burst 3; read each back -> identical values, each done one cycle after ci_start; write with ci_n!=CUSTOM_ID -> no done.
- Read transfer, block 8, burst 3, buffer start 5: two requests, burst_size_out=3 both times, address_out 0x1000_0040 then 0x1000_0050. Data 0xA0..0xA7 lands at buffer 5..12; busy is 0 afterwards.
- Write transfer, block 5, burst 3, bus_busy held 2 cycles on beat 2: bursts of 4 then 1 beat (burst_size_out 3 then 0). data_out holds during the stall; end_transaction_out pulses twice.
- Buffer wrap: buffer start 510, block 4 read -> words land at 510, 511, 0, 1.
- bus_error on beat 2 of burst 1 -> bus outputs 0 next cycle, status=2'b10. A write of control=0 clears it to 0. Config writes during the transfer are ignored.
- Reset asserted in WRITE -> outputs 0 next cycle; a new transfer after reset completes normally.
